// File: rtl/dmni_rx_arbiter.sv
// Multi-channel DMNI receive front-end: one credit-controlled ring FIFO per
// Hermes input channel, merged onto a single DMA-facing flit stream with
// packet-atomic arbitration (round-robin or fixed priority).
module dmni_rx_arbiter #(
  parameter int FLIT_SIZE   = 32,
  parameter int N_CH        = 2,
  parameter int BUFFER_SIZE = 16,
  parameter int ARB_MODE    = 0,
  localparam int CHW        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CW         = $clog2(BUFFER_SIZE) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_CH-1:0]                rx_i,
  input  logic [N_CH-1:0]                eop_i,
  output logic [N_CH-1:0]                credit_o,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0] data_i,
  output logic                           tx_o,
  output logic                           eop_o,
  output logic [CHW-1:0]                 ch_o,
  input  logic                           ack_i,
  output logic [FLIT_SIZE-1:0]           data_o,
  output logic [N_CH-1:0][CW-1:0]        level_o
);

  localparam int PW = $clog2(BUFFER_SIZE);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                   state;
  logic [CHW-1:0]           grant;
  logic [CHW-1:0]           last_grant;
  logic [CHW-1:0]           winner;
  logic                     any_req;
  int unsigned              idx;

  logic [FLIT_SIZE:0]       mem [N_CH][BUFFER_SIZE];
  logic [N_CH-1:0][PW-1:0]  wr_ptr;
  logic [N_CH-1:0][PW-1:0]  rd_ptr;
  logic [N_CH-1:0][CW-1:0]  count;

  logic [N_CH-1:0]          push;
  logic [N_CH-1:0]          pop;
  logic [FLIT_SIZE:0]       head;

  assign level_o = count;

  // Credits, push/pop qualification and the merged output stream
  always_comb begin
    credit_o = '0;
    push     = '0;
    pop      = '0;
    head     = mem[grant][rd_ptr[grant]];
    tx_o     = (state == LOCK) && (count[grant] != '0);
    data_o   = tx_o ? head[FLIT_SIZE-1:0] : '0;
    eop_o    = tx_o ? head[FLIT_SIZE] : 1'b0;
    ch_o     = grant;
    for (int unsigned c = 0; c < N_CH; c++) begin
      credit_o[c] = (count[c] != CW'(BUFFER_SIZE));
      push[c]     = rx_i[c] && credit_o[c];
      pop[c]      = tx_o && ack_i && (grant == CHW'(c));
    end
  end

  // Winner selection: scan starts after last_grant (round-robin) or at 0 (priority)
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ARB_MODE == 1) idx = i;
      else               idx = (32'(last_grant) + 1 + i) % N_CH;
      if (!any_req && (count[idx] != '0)) begin
        winner  = CHW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // FIFO storage; no reset needed since pointers/counts gate visibility
  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= {eop_i[c], data_i[c]};
    end
  end

  // Per-channel pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
        else if (!push[c] && pop[c]) count[c] <= count[c] - 1'b1;
      end
    end
  end

  // Packet-atomic arbitration FSM: lock a channel until its eop flit is popped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CHW'(N_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= winner;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (tx_o && ack_i && head[FLIT_SIZE]) begin
            state      <= IDLE;
            last_grant <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmni_rx_arbiter.sv
// Scoreboard bench for dmni_rx_arbiter: a round-robin and a fixed-priority
// instance share all inputs; each has its own expected-flit queue.
module tb_dmni_rx_arbiter;

  localparam int FS = 32;
  localparam int NC = 2;
  localparam int BS = 16;
  localparam int LW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i = 1'b1;
  logic [NC-1:0]          rx_i  = '0;
  logic [NC-1:0]          eop_i = '0;
  logic [NC-1:0][FS-1:0]  data_i = '0;
  logic                   ack_i = 1'b0;

  logic [NC-1:0]          credit_a, credit_b;
  logic                   tx_a, tx_b, eop_a, eop_b;
  logic [0:0]             ch_a, ch_b;
  logic [FS-1:0]          data_a, data_b;
  logic [NC-1:0][LW-1:0]  level_a, level_b;

  dmni_rx_arbiter #(.FLIT_SIZE(FS), .N_CH(NC), .BUFFER_SIZE(BS), .ARB_MODE(0)) dut_rr (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .eop_i(eop_i), .credit_o(credit_a),
    .data_i(data_i), .tx_o(tx_a), .eop_o(eop_a), .ch_o(ch_a), .ack_i(ack_i),
    .data_o(data_a), .level_o(level_a)
  );

  dmni_rx_arbiter #(.FLIT_SIZE(FS), .N_CH(NC), .BUFFER_SIZE(BS), .ARB_MODE(1)) dut_fp (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .eop_i(eop_i), .credit_o(credit_b),
    .data_i(data_i), .tx_o(tx_b), .eop_o(eop_b), .ch_o(ch_b), .ack_i(ack_i),
    .data_o(data_b), .level_o(level_b)
  );

  int total = 0;
  int bad   = 0;

  logic [33:0] q_rr[$];
  logic [33:0] q_fp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] item(input logic c, input logic e, input logic [31:0] d);
    return {c, e, d};
  endfunction

  // Output monitor: compare every accepted flit and the idle cycle after each eop
  initial begin
    bit gap_rr = 0;
    bit gap_fp = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        gap_rr = 0;
        gap_fp = 0;
      end else begin
        if (gap_rr) check("gap_rr", tx_a, 0);
        if (gap_fp) check("gap_fp", tx_b, 0);
        if (tx_a && ack_i) begin
          if (q_rr.size() == 0) check("extra_rr", tx_a, 0);
          else check("out_rr", {ch_a, eop_a, data_a}, q_rr.pop_front());
        end
        if (tx_b && ack_i) begin
          if (q_fp.size() == 0) check("extra_fp", tx_b, 0);
          else check("out_fp", {ch_b, eop_b, data_b}, q_fp.pop_front());
        end
        gap_rr = tx_a && ack_i && eop_a;
        gap_fp = tx_b && ack_i && eop_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic v0, input logic [31:0] d0, input logic e0,
                       input logic v1, input logic [31:0] d1, input logic e1);
    rx_i      = {v1, v0};
    eop_i     = {e1, e0};
    data_i[0] = d0;
    data_i[1] = d1;
    tick();
    rx_i  = '0;
    eop_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rx_i  = '0;
    eop_i = '0;
    tick();
    rst_i = 1'b0;
    q_rr.delete();
    q_fp.delete();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_rr.size() != 0 || q_fp.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_rr", q_rr.size(), 0);
    check("drain_fp", q_fp.size(), 0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal;
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_credit", credit_a, 2'b11);
    check("rst_tx", tx_a, 0);
    check("rst_eop", eop_a, 0);
    check("rst_ch", ch_a, 0);
    check("rst_data", data_a, 0);
    check("rst_level", level_a, 0);

    // Single 3-flit packet on ch0: latency and streaming
    ack_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      q_rr.push_back(item(0, f == 2, 32'hA0 + f));
      q_fp.push_back(item(0, f == 2, 32'hA0 + f));
    end
    rx_i[0] = 1'b1; data_i[0] = 32'hA0; eop_i[0] = 1'b0;
    tick();
    data_i[0] = 32'hA1;
    @(negedge clk);
    check("lat_idle", tx_a, 0);
    tick();
    data_i[0] = 32'hA2; eop_i[0] = 1'b1;
    @(negedge clk);
    check("lat_tx", tx_a, 1);
    check("lat_data", data_a, 32'hA0);
    tick();
    rx_i = '0; eop_i = '0;
    wait_drain();
    repeat (2) tick();
    check("lvl0_empty", level_a[0], 0);

    // Two 2-flit packets preloaded on each channel: RR interleaves, FP drains ch0 first
    do_reset();
    ack_i = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 2; f++) q_rr.push_back(item(0, f == 1, 32'h100 + p * 2 + f));
      for (int f = 0; f < 2; f++) q_rr.push_back(item(1, f == 1, 32'h200 + p * 2 + f));
    end
    for (int p = 0; p < 4; p++) q_fp.push_back(item(0, p % 2 == 1, 32'h100 + p));
    for (int p = 0; p < 4; p++) q_fp.push_back(item(1, p % 2 == 1, 32'h200 + p));
    for (int p = 0; p < 2; p++)
      for (int f = 0; f < 2; f++)
        push2(1, 32'h100 + p * 2 + f, f == 1, 1, 32'h200 + p * 2 + f, f == 1);
    check("pre_lvl0", level_a[0], 4);
    check("pre_lvl1", level_b[1], 4);
    ack_i = 1'b1;
    wait_drain();

    // Fill ch1 with ack low: credit drops, overflow flit ignored, output held stable
    do_reset();
    ack_i = 1'b0;
    for (int i = 0; i < BS; i++) begin
      q_rr.push_back(item(1, i == BS - 1, 32'h300 + i));
      q_fp.push_back(item(1, i == BS - 1, 32'h300 + i));
    end
    for (int i = 0; i < BS; i++) push2(0, 0, 0, 1, 32'h300 + i, i == BS - 1);
    check("full_credit", credit_a[1], 0);
    check("full_credit_fp", credit_b[1], 0);
    check("full_level", level_a[1], 16);
    check("stall_tx", tx_a, 1);
    check("stall_ch", ch_a, 1);
    push2(0, 0, 0, 1, 32'hDEAD, 1);
    check("ovf_level", level_a[1], 16);
    check("stall_data", data_a, 32'h300);
    check("stall_eop", eop_a, 0);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check("credit_back", credit_a[1], 1);
    check("level_15", level_a[1], 15);
    check("next_head", data_a, 32'h301);
    ack_i = 1'b1;
    wait_drain();

    // Ch0 pauses mid-packet while ch1 waits: lock is held on ch0
    do_reset();
    ack_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      q_rr.push_back(item(0, f == 2, 32'h400 + f));
      q_fp.push_back(item(0, f == 2, 32'h400 + f));
    end
    for (int f = 0; f < 2; f++) begin
      q_rr.push_back(item(1, f == 1, 32'h500 + f));
      q_fp.push_back(item(1, f == 1, 32'h500 + f));
    end
    push2(1, 32'h400, 0, 1, 32'h500, 0);
    push2(1, 32'h401, 0, 1, 32'h501, 1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("pause_tx_rr", tx_a, 0);
      check("pause_tx_fp", tx_b, 0);
      check("pause_ch", ch_a, 0);
      tick();
    end
    check("pause_lvl1", level_a[1], 2);
    push2(1, 32'h402, 1, 0, 0, 0);
    wait_drain();

    // Reset mid-packet with 5 flits buffered on ch0, then a clean packet
    do_reset();
    ack_i = 1'b0;
    for (int i = 0; i < 5; i++) push2(1, 32'h600 + i, 0, 0, 0, 0);
    check("pre_rst_lvl", level_a[0], 5);
    rst_i = 1'b1;
    tick();
    check("mid_rst_level", level_a, 0);
    check("mid_rst_tx", tx_a, 0);
    check("mid_rst_credit", credit_a, 2'b11);
    check("mid_rst_data", data_a, 0);
    rst_i = 1'b0;
    ack_i = 1'b1;
    for (int f = 0; f < 2; f++) begin
      q_rr.push_back(item(0, f == 1, 32'h700 + f));
      q_fp.push_back(item(0, f == 1, 32'h700 + f));
    end
    push2(1, 32'h700, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_idle", tx_a, 0);
    push2(1, 32'h701, 1, 0, 0, 0);
    wait_drain();
    repeat (2) tick();
    check("post_rst_lvl", level_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
